// File: rtl/chip8_mem_pkg.sv
// Shared constants and types for the CHIP-8 unified memory port-A arbiter.
// Holds region bases and depths, processor access types, requester IDs and the completion tag.
package chip8_mem_pkg;

    localparam logic [1:0] PROC_MEM_TYPE_RAM = 2'd0;
    localparam logic [1:0] PROC_MEM_TYPE_REG = 2'd1;
    localparam logic [1:0] PROC_MEM_TYPE_STK = 2'd2;

    localparam int RAM_BASE  = 0;
    localparam int VRAM_BASE = 4096;
    localparam int REG_BASE  = 4352;
    localparam int STK_BASE  = 4375;

    localparam int REG_DEPTH = 23;
    localparam int STK_DEPTH = 32;
    localparam int DEPTH     = 4407;

    typedef enum logic [1:0] {
        REQ_PROC,
        REQ_VIDEO,
        REQ_FLASH
    } req_e;

    typedef struct packed {
        logic valid;
        req_e id;
        logic err;
    } tag_t;

    // Round-robin successor in the fixed PROC -> VIDEO -> FLASH ring.
    function automatic req_e next_req(req_e r);
        case (r)
            REQ_PROC:  return REQ_VIDEO;
            REQ_VIDEO: return REQ_FLASH;
            default:   return REQ_PROC;
        endcase
    endfunction

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Requester handshakes and BRAM port-A command bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface chip8_mem_arbiter_if #(
    parameter int ADDR_W = 13
);
    logic              proc_valid_in;
    logic              proc_ready_out;
    logic              proc_we_in;
    logic [1:0]        proc_type_in;
    logic [11:0]       proc_addr_in;
    logic [7:0]        proc_data_in;
    logic              proc_valid_out;
    logic              proc_err_out;

    logic              video_valid_in;
    logic              video_ready_out;
    logic              video_we_in;
    logic [7:0]        video_addr_in;
    logic [7:0]        video_data_in;
    logic              video_valid_out;

    logic              flash_valid_in;
    logic              flash_ready_out;
    logic [11:0]       flash_addr_in;
    logic [7:0]        flash_data_in;
    logic              flash_valid_out;

    logic              mem_en_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [7:0]        mem_data_out;

    modport slave (
        input  proc_valid_in, proc_we_in, proc_type_in, proc_addr_in, proc_data_in,
        output proc_ready_out, proc_valid_out, proc_err_out,
        input  video_valid_in, video_we_in, video_addr_in, video_data_in,
        output video_ready_out, video_valid_out,
        input  flash_valid_in, flash_addr_in, flash_data_in,
        output flash_ready_out, flash_valid_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_data_out
    );

    modport master (
        output proc_valid_in, proc_we_in, proc_type_in, proc_addr_in, proc_data_in,
        input  proc_ready_out, proc_valid_out, proc_err_out,
        output video_valid_in, video_we_in, video_addr_in, video_data_in,
        input  video_ready_out, video_valid_out,
        output flash_valid_in, flash_addr_in, flash_data_in,
        input  flash_ready_out, flash_valid_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_data_out
    );

endinterface

// File: rtl/chip8_pipeline.sv
// Generic resettable delay line: q is d delayed by STAGES clock cycles.
module chip8_pipeline #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: every stage is reset because it carries valid bits; a stale entry would complete after reset.
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/chip8_rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
module chip8_rr_arbiter3
    import chip8_mem_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output req_e       winner,
    output logic       any_grant
);

    req_e ptr;
    req_e cand1;
    req_e cand2;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cand1     = next_req(ptr);
        cand2     = next_req(cand1);
        grant     = '0;
        winner    = ptr;
        any_grant = 1'b1;
        if (req[ptr])        winner = ptr;
        else if (req[cand1]) winner = cand1;
        else if (req[cand2]) winner = cand2;
        else                 any_grant = 1'b0;
        if (any_grant) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_in)      ptr <= REQ_PROC;
        else if (any_grant) ptr <= next_req(winner);
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Arbitrates processor, video and flash loader onto BRAM port A, one registered command per cycle.
// A tag delay line returns each requester's completion pulse aligned with BRAM read data.
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    chip8_mem_arbiter_if.slave   bus
);

    logic [2:0]        req;
    logic [2:0]        grant;
    req_e              winner;
    logic              any_grant;

    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              sel_we;
    logic              sel_err;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;

    tag_t              tag_in;
    tag_t              tag_out;

    // Requests are masked while reset is held so no ready_out is shown then.
    assign req = {bus.flash_valid_in, bus.video_valid_in, bus.proc_valid_in} & {3{rst_n_in}};

    chip8_rr_arbiter3 u_arb (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .req       (req),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign bus.proc_ready_out  = grant[REQ_PROC];
    assign bus.video_ready_out = grant[REQ_VIDEO];
    assign bus.flash_ready_out = grant[REQ_FLASH];

    always_comb begin
        sel_addr = ADDR_W'(RAM_BASE) + ADDR_W'(bus.proc_addr_in);
        sel_data = bus.proc_data_in;
        sel_we   = bus.proc_we_in;
        sel_err  = 1'b0;
        case (winner)
            REQ_PROC: begin
                case (bus.proc_type_in)
                    PROC_MEM_TYPE_RAM: ;
                    PROC_MEM_TYPE_REG: begin
                        sel_addr = ADDR_W'(REG_BASE) + ADDR_W'(bus.proc_addr_in);
                        sel_err  = bus.proc_addr_in >= 12'(REG_DEPTH);
                    end
                    PROC_MEM_TYPE_STK: begin
                        sel_addr = ADDR_W'(STK_BASE) + ADDR_W'(bus.proc_addr_in);
                        sel_err  = bus.proc_addr_in >= 12'(STK_DEPTH);
                    end
                    default: sel_err = 1'b1;
                endcase
            end
            REQ_VIDEO: begin
                sel_addr = ADDR_W'(VRAM_BASE) + ADDR_W'(bus.video_addr_in);
                sel_data = bus.video_data_in;
                sel_we   = bus.video_we_in;
            end
            default: begin
                sel_addr = ADDR_W'(RAM_BASE) + ADDR_W'(bus.flash_addr_in);
                sel_data = bus.flash_data_in;
                sel_we   = 1'b1;
            end
        endcase
    end

    // Erroneous requests are accepted but never reach the BRAM pins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_en_q <= any_grant && !sel_err;
            mem_we_q <= any_grant && !sel_err && sel_we;
            if (any_grant) begin
                mem_addr_q <= sel_addr;
                mem_data_q <= sel_data;
            end
        end
    end

    assign bus.mem_en_out   = mem_en_q;
    assign bus.mem_we_out   = mem_we_q;
    assign bus.mem_addr_out = mem_addr_q;
    assign bus.mem_data_out = mem_data_q;

    assign tag_in = '{valid: any_grant, id: winner, err: sel_err};

    chip8_pipeline #(
        .WIDTH  ($bits(tag_t)),
        .STAGES (RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d        (tag_in),
        .q        (tag_out)
    );

    assign bus.proc_valid_out  = tag_out.valid && (tag_out.id == REQ_PROC);
    assign bus.proc_err_out    = bus.proc_valid_out && tag_out.err;
    assign bus.video_valid_out = tag_out.valid && (tag_out.id == REQ_VIDEO);
    assign bus.flash_valid_out = tag_out.valid && (tag_out.id == REQ_FLASH);

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
Shares port A of the CHIP-8 unified memory BRAM between three requesters: processor (RAM/REG/STK accesses), video (framebuffer byte r/w) and flash loader (ROM copy into RAM, write-only). Each requester uses a valid/ready handshake. The block arbitrates round-robin, maps each request into the flat BRAM address space, and drives one registered BRAM command per cycle. It tags every issued command so the matching requester gets a valid pulse aligned with BRAM read data. Port B (HDMI) is outside this block.

Parameters:
RD_LATENCY, 2, BRAM read latency in cycles from command at BRAM pins to douta valid
ADDR_W, 13, flat BRAM address width (covers 4407 bytes)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
proc_valid_in  input  1  processor request present
proc_ready_out  output  1  processor request accepted this cycle
proc_we_in  input  1  processor write enable
proc_type_in  input  2  0=RAM, 1=REG, 2=STK, 3=invalid
proc_addr_in  input  12  offset within the selected region
proc_data_in  input  8  processor write data
proc_valid_out  output  1  processor access complete; BRAM data valid if read
proc_err_out  output  1  qualifies proc_valid_out: invalid type or out-of-range offset
video_valid_in  input  1  video request present
video_ready_out  output  1  video request accepted
video_we_in  input  1  video write enable
video_addr_in  input  8  framebuffer byte index 0..255
video_data_in  input  8  video write data
video_valid_out  output  1  video access complete
flash_valid_in  input  1  flash write request present
flash_ready_out  output  1  flash request accepted
flash_addr_in  input  12  RAM address
flash_data_in  input  8  flash write data
flash_valid_out  output  1  flash write committed
mem_en_out  output  1  BRAM port A enable
mem_we_out  output  1  BRAM port A write enable
mem_addr_out  output  ADDR_W  BRAM port A address
mem_data_out  output  8  BRAM port A write data

Behaviour:
- Reset (async assert, sync release): all outputs 0, round-robin pointer = PROC, tag pipeline cleared. In-flight accesses are dropped; no valid_out appears after reset.
- Handshake: a transfer occurs when valid_in && ready_out in the same cycle. ready_out is combinational from the valid_ins and the pointer. At most one ready_out is high per cycle. A requester holds its inputs stable until accepted.
- Arbitration: round-robin in the order PROC, VIDEO, FLASH, starting at the pointer. After a grant, the pointer moves to the requester after the winner. With no request, the pointer is unchanged.
- Throughput: one acceptance per cycle, no bubbles.
- Issue: at acceptance cycle T, mem_en/we/addr/data are registered and present during T+1. With no acceptance, mem_en_out=0 and mem_we_out=0; addr/data hold.
- Address map:
  - RAM: proc_addr or flash_addr.
  - VIDEO: 4096 + video_addr.
  - REG: 4352 + offset, valid offsets 0..22.
  - STK: 4375 + offset, valid offsets 0..31.
- Errors: proc_type 3, or a REG/STK offset beyond its range, is still accepted. mem_en_out and mem_we_out stay 0 during T+1. The request still occupies its tag slot and returns proc_valid_out with proc_err_out=1.
- Completion: a tag (requester ID plus err bit) travels an (RD_LATENCY+1)-stage shift register from the acceptance cycle. The matching valid_out is a single-cycle pulse during T+1+RD_LATENCY, aligned with douta. Writes complete the same way.
- Order: completions return in acceptance order. Every requester may have several outstanding requests.
- proc_err_out is 0 whenever proc_valid_out is 0.

Decomposition:
- Package chip8_mem_pkg holds:
  - PROC_MEM_TYPE_RAM/REG/STK constants
  - region bases RAM_BASE=0, VRAM_BASE=4096, REG_BASE=4352, STK_BASE=4375
  - depths REG_DEPTH=23, STK_DEPTH=32, DEPTH=4407
  - requester enum {REQ_PROC, REQ_VIDEO, REQ_FLASH}
- Sub-module chip8_rr_arbiter3 holds the combinational grant plus the registered pointer.
- The tag delay line uses the existing pipeline module.

Test Plan:
- Single proc read: type REG, offset 5, accepted at T -> mem_addr_out=4357, mem_en=1, mem_we=0 at T+1; proc_valid_out=1, proc_err_out=0 at T+3; no other valid_out.
- All three valid continuously from reset with fixed inputs -> grants go PROC, VIDEO, FLASH, PROC, ... one per cycle; valid_outs follow the same order 3 cycles after each grant.
- Flash write addr 0x200 data 0xA5 -> mem_we=1, mem_addr=512, mem_data=0xA5 for one cycle; flash_valid_out 3 cycles after acceptance.
- Proc type 3, and separately STK offset 40 -> accepted; mem_en stays 0; proc_valid_out with proc_err_out=1 at T+3.
- Video write addr 255 followed by video read addr 255 -> mem_addr 4351 both times; second valid_out aligns with douta returning the written value.
- Assert rst_n_in mid-stream with 2 accesses in flight -> all outputs 0 immediately; no valid_out after release; first grant after release goes to PROC.
